modarith_serial: RTL and testbench



---
 rtl/modarith_serial.sv | 114 +++++++++++
 tb/tb_modarith_serial.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/modarith_serial.sv
// modarith_serial: limb-serial modular add/sub/neg/dbl, two carry-chain passes plus a select cycle
module modarith_serial #(
    parameter int WIDTH = 381,
    parameter int LIMB = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    input  logic             out_read,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int NLIMB = (WIDTH + LIMB) / LIMB;
    localparam int W = NLIMB * LIMB;
    localparam int CW = NLIMB > 1 ? $clog2(NLIMB) : 1;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, NEG = 2'b10, DBL = 2'b11;

    typedef enum logic [2:0] {IDLE, P1, P2, SEL, DONE} state_t;

    state_t state, state_nx;
    logic [W-1:0] a, b, m, x, y;
    logic [1:0] op_r;
    logic c, f1, last;
    logic [CW-1:0] cnt;
    logic [LIMB-1:0] p, q;
    logic [LIMB:0] sum;

    function automatic logic [W-1:0] rot(input logic [W-1:0] v);
        return (v >> LIMB) | (v << (W - LIMB));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? P1 : IDLE;
            P1: state_nx = last ? P2 : P1;
            P2: state_nx = last ? SEL : P2;
            SEL: state_nx = DONE;
            DONE: state_nx = out_read ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = state == IDLE;
        busy = state inside {P1, P2, SEL};
        done = state == DONE;
    end

    // Operand registers rotate one limb per cycle so limb 0 of each is always the live limb.
    always_comb begin
        last = cnt == CW'(NLIMB - 1);
        p = state == P2 ? x[LIMB-1:0] : op_r == NEG ? m[LIMB-1:0] : a[LIMB-1:0];
        q = state == P2 ? (op_r == SUB ? m[LIMB-1:0] : ~m[LIMB-1:0]) :
            op_r == ADD ? b[LIMB-1:0] : op_r == DBL ? a[LIMB-1:0] :
            op_r == NEG ? ~a[LIMB-1:0] : ~b[LIMB-1:0];
        sum = {1'b0, p} + {1'b0, q} + (LIMB + 1)'(c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            m <= '0;
            x <= '0;
            y <= '0;
            op_r <= '0;
            c <= 1'b0;
            f1 <= 1'b0;
            cnt <= '0;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                a <= W'(in_a);
                b <= W'(in_b);
                m <= W'(in_m);
                op_r <= op;
                c <= ^op;
                cnt <= '0;
            end
            if (state == P1 || state == P2) begin
                c <= sum[LIMB];
                cnt <= last ? '0 : cnt + 1'b1;
                m <= rot(m);
            end
            if (state == P1) begin
                a <= rot(a);
                b <= rot(b);
                x <= (x >> LIMB) | (W'(sum[LIMB-1:0]) << (W - LIMB));
                if (last) begin
                    f1 <= ~sum[LIMB];
                    c <= op_r != SUB;
                end
            end
            if (state == P2) begin
                x <= rot(x);
                y <= (y >> LIMB) | (W'(sum[LIMB-1:0]) << (W - LIMB));
            end
            if (state == SEL)
                result <= op_r == SUB ? (f1 ? y[WIDTH-1:0] : x[WIDTH-1:0]) : (c ? y[WIDTH-1:0] : x[WIDTH-1:0]);
        end
    end
endmodule

// File: tb/tb_modarith_serial.sv
// tb_modarith_serial: directed 8-bit checks plus randomized wide checks against a modular-arithmetic model
module tb_modarith_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0, nfail = 0;

    logic r8, s8, rd8, rdy8, bsy8, dn8;
    logic [1:0] op8;
    logic [7:0] a8, b8, m8, res8;
    modarith_serial #(.WIDTH(8), .LIMB(4)) u8 (
        .clk(clk), .reset(r8), .start(s8), .op(op8), .in_a(a8), .in_b(b8), .in_m(m8),
        .out_read(rd8), .ready(rdy8), .busy(bsy8), .done(dn8), .result(res8));

    logic rw, sw, rdw, rdy_a, bsy_a, dn_a, rdy_b, bsy_b, dn_b;
    logic [1:0] opw;
    logic [380:0] aw, bw, mw, res_a, res_b, big_m;
    modarith_serial u_a (
        .clk(clk), .reset(rw), .start(sw), .op(opw), .in_a(aw), .in_b(bw), .in_m(mw),
        .out_read(rdw), .ready(rdy_a), .busy(bsy_a), .done(dn_a), .result(res_a));
    modarith_serial #(.LIMB(32)) u_b (
        .clk(clk), .reset(rw), .start(sw), .op(opw), .in_a(aw), .in_b(bw), .in_m(mw),
        .out_read(rdw), .ready(rdy_b), .busy(bsy_b), .done(dn_b), .result(res_b));

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [380:0] rnd();
        logic [383:0] v = '0;
        for (int i = 0; i < 12; i++) v = {v[351:0], 32'($urandom)};
        return v[380:0];
    endfunction

    function automatic logic [380:0] model(input logic [1:0] o, input logic [380:0] a, input logic [380:0] b, input logic [380:0] m);
        logic [381:0] x, mm;
        mm = {1'b0, m};
        x = o == 2'd0 ? a + b : o == 2'd1 ? a + mm - b : o == 2'd2 ? mm - a : a + a;
        return 381'(x % mm);
    endfunction

    task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp, input string tag, input bit rel);
        int lat = 0;
        int nb;
        op8 = o; a8 = a; b8 = b; m8 = 8'd251; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        nb = int'(bsy8);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom); s8 = 1'($urandom);
            @(posedge clk); #1;
            if (dn8) lat = n;
            else nb += int'(bsy8);
        end
        s8 = 1'b0; m8 = 8'd251;
        chk({tag, " result"}, 384'(res8), 384'(exp));
        chk({tag, " latency"}, 384'(lat), 384'(7));
        chk({tag, " busy cycles"}, 384'(nb), 384'(7));
        if (rel) begin
            rd8 = 1'b1;
            @(posedge clk); #1;
            rd8 = 1'b0;
            chk({tag, " ready after read"}, 384'(rdy8), 384'(1));
        end
    endtask

    task automatic go_w(input logic [1:0] o, input logic [380:0] a, input logic [380:0] b, input string tag);
        int lat_a = 0, lat_b = 0;
        logic [380:0] exp, ga, gb;
        exp = model(o, a, b, big_m);
        ga = '0; gb = '0;
        opw = o; aw = a; bw = b; mw = big_m; sw = 1'b1;
        @(posedge clk); #1;
        sw = 1'b0;
        for (int n = 1; n <= 60 && (lat_a == 0 || lat_b == 0); n++) begin
            opw = 2'($urandom); aw = rnd(); bw = rnd(); mw = rnd();
            @(posedge clk); #1;
            if (lat_a == 0 && dn_a) begin lat_a = n; ga = res_a; end
            if (lat_b == 0 && dn_b) begin lat_b = n; gb = res_b; end
        end
        chk({tag, " result L64"}, 384'(ga), 384'(exp));
        chk({tag, " result L32"}, 384'(gb), 384'(exp));
        chk({tag, " latency L64"}, 384'(lat_a), 384'(13));
        chk({tag, " latency L32"}, 384'(lat_b), 384'(25));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [383:0] p384;
        int bad;
        logic [380:0] ra, rb;
        logic [1:0] ro;
        p384 = 384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;
        big_m = p384[380:0];
        r8 = 1'b1; rw = 1'b1; s8 = 1'b0; sw = 1'b0; rd8 = 1'b0; rdw = 1'b1;
        op8 = '0; a8 = '0; b8 = '0; m8 = 8'd251;
        opw = '0; aw = '0; bw = '0; mw = big_m;
        repeat (2) @(posedge clk);
        #1;
        r8 = 1'b0; rw = 1'b0;
        chk("reset ready8", 384'(rdy8), 384'(1));
        chk("reset busy8", 384'(bsy8), 384'(0));
        chk("reset done8", 384'(dn8), 384'(0));
        chk("reset result8", 384'(res8), 384'(0));
        chk("reset ready64", 384'(rdy_a), 384'(1));
        chk("reset done64", 384'(dn_a), 384'(0));
        chk("reset result32", 384'(res_b), 384'(0));

        run8(2'd0, 8'd200, 8'd100, 8'd49, "add 200+100", 1'b1);
        run8(2'd1, 8'd10, 8'd20, 8'd241, "sub 10-20", 1'b1);
        run8(2'd1, 8'd20, 8'd20, 8'd0, "sub 20-20", 1'b1);
        run8(2'd3, 8'd250, 8'd0, 8'd249, "dbl 250", 1'b1);
        run8(2'd2, 8'd0, 8'd77, 8'd0, "neg 0", 1'b1);
        run8(2'd2, 8'd5, 8'd0, 8'd246, "neg 5", 1'b0);

        bad = 0;
        for (int n = 0; n < 20; n++) begin
            s8 = 1'($urandom); op8 = 2'($urandom); a8 = 8'($urandom);
            @(posedge clk); #1;
            if (res8 !== 8'd246 || dn8 !== 1'b1) bad++;
        end
        chk("done hold 20 cycles", 384'(bad), 384'(0));
        s8 = 1'b1; rd8 = 1'b1; op8 = 2'd0;
        @(posedge clk); #1;
        s8 = 1'b0; rd8 = 1'b0;
        chk("start+read ready", 384'(rdy8), 384'(1));
        chk("start+read no op", 384'(bsy8), 384'(0));
        @(posedge clk); #1;
        chk("start+read still idle", 384'(bsy8), 384'(0));

        op8 = 2'd0; a8 = 8'd3; b8 = 8'd4; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy before reset", 384'(bsy8), 384'(1));
        r8 = 1'b1;
        @(posedge clk); #1;
        r8 = 1'b0;
        chk("midop reset ready", 384'(rdy8), 384'(1));
        chk("midop reset done", 384'(dn8), 384'(0));
        chk("midop reset busy", 384'(bsy8), 384'(0));
        chk("midop reset result", 384'(res8), 384'(0));
        run8(2'd0, 8'd1, 8'd1, 8'd2, "add 1+1 after reset", 1'b1);

        for (int i = 0; i < 100; i++) begin
            ro = 2'($urandom);
            ra = rnd() % big_m;
            rb = rnd() % big_m;
            if (i == 0) begin ro = 2'd0; ra = big_m - 381'd1; rb = 381'd1; end
            if (i == 1) begin ro = 2'd2; ra = '0; end
            if (i == 2) begin ro = 2'd1; rb = ra; end
            if (i == 3) begin ro = 2'd3; ra = big_m - 381'd1; end
            go_w(ro, ra, rb, $sformatf("wide #%0d op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
